sfx_scheduler: RTL

Frame-synchronous sound-effect arbiter between game-event sources and the APU. Four event requests (collision and game-state levels) share one effect voice. The block latches rising edges, picks the highest-priority pending effect at each frame boundary, and sequences its per-frame index. It also ducks the background-music channel while an effect plays and for a short hold time afterwards. It sits between the CollisionDetector/game-state logic and the APU, and all decisions are qualified by the sync generator's frame tick.

---
 rtl/sfx_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sfx_scheduler.sv
// Purpose : frame-synchronous sound-effect arbiter; latches request edges, plays the
//           highest-priority pending effect and ducks background music around it.
// Latency : rise -> pending 1 clk; start outputs 1 clk after the serving frame_tick.
// Backpressure: none; requests are latched and held until served (one per bit).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   frame_tick        one-cycle pulse per video frame; qualifies all FSM updates
//   req[3:0]          event request levels, bit n requests effect n
//   bgm_en            background music enabled by game state
//   sfx_active        effect currently playing
//   sfx_id[1:0]       effect being played (holds last value when idle)
//   sfx_frame[4:0]    frames elapsed in current effect
//   sfx_start         one-cycle pulse on effect start/restart (APU envelope reset)
//   bgm_gate          music allowed: bgm_en and no effect playing or holding
//   pending[3:0]      latched, not-yet-served requests
module sfx_scheduler #(
    parameter int DUR0      = 24,
    parameter int DUR1      = 8,
    parameter int DUR2      = 16,
    parameter int DUR3      = 31,
    parameter int DUCK_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [3:0] req,
    input  logic       bgm_en,
    output logic       sfx_active,
    output logic [1:0] sfx_id,
    output logic [4:0] sfx_frame,
    output logic       sfx_start,
    output logic       bgm_gate,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] req_q;
    logic [3:0] pending_q, pending_d;
    logic [1:0] sfx_id_q, sfx_id_d;
    logic [4:0] sfx_frame_q, sfx_frame_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       sfx_start_q, sfx_start_d;

    logic [3:0] rise;
    logic [3:0] clr;
    logic [1:0] winner;
    logic [4:0] last_frame;
    logic       start_ok;

    assign rise = req & ~req_q;

    // Fixed priority: highest set bit of the registered pending vector.
    always_comb begin
        winner = 2'd0;
        if (pending_q[3])      winner = 2'd3;
        else if (pending_q[2]) winner = 2'd2;
        else if (pending_q[1]) winner = 2'd1;
        else                   winner = 2'd0;
    end

    // Last frame index of the effect currently selected.
    always_comb begin
        case (sfx_id_q)
            2'd0:    last_frame = 5'(DUR0 - 1);
            2'd1:    last_frame = 5'(DUR1 - 1);
            2'd2:    last_frame = 5'(DUR2 - 1);
            default: last_frame = 5'(DUR3 - 1);
        endcase
    end

    // Equal priority restarts, higher priority preempts; anything wins outside PLAY.
    assign start_ok = (pending_q != 4'd0) && ((state_q != PLAY) || (winner >= sfx_id_q));

    always_comb begin
        state_d     = state_q;
        sfx_id_d    = sfx_id_q;
        sfx_frame_d = sfx_frame_q;
        hold_cnt_d  = hold_cnt_q;
        sfx_start_d = 1'b0;
        clr         = 4'd0;
        if (frame_tick) begin
            if (start_ok) begin
                state_d     = PLAY;
                sfx_id_d    = winner;
                sfx_frame_d = 5'd0;
                sfx_start_d = 1'b1;
                clr[winner] = 1'b1;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (sfx_frame_q == last_frame) begin
                            // Frame index freezes at its last value after the effect ends.
                            if (DUCK_HOLD == 0) begin
                                state_d = IDLE;
                            end else begin
                                state_d    = HOLD;
                                hold_cnt_d = 4'(DUCK_HOLD);
                            end
                        end else begin
                            sfx_frame_d = sfx_frame_q + 5'd1;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt_q == 4'd1) state_d    = IDLE;
                        else                    hold_cnt_d = hold_cnt_q - 4'd1;
                    end
                    default: ;
                endcase
            end
        end
        // A new rise on a bit being cleared this cycle keeps the bit set.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 4'd0;
            pending_q   <= 4'd0;
            sfx_id_q    <= 2'd0;
            sfx_frame_q <= 5'd0;
            hold_cnt_q  <= 4'd0;
            sfx_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req;
            pending_q   <= pending_d;
            sfx_id_q    <= sfx_id_d;
            sfx_frame_q <= sfx_frame_d;
            hold_cnt_q  <= hold_cnt_d;
            sfx_start_q <= sfx_start_d;
        end
    end

    assign sfx_active = (state_q == PLAY);
    assign sfx_id     = sfx_id_q;
    assign sfx_frame  = sfx_frame_q;
    assign sfx_start  = sfx_start_q;
    assign bgm_gate   = bgm_en && (state_q == IDLE);
    assign pending    = pending_q;

endmodule
